// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register index and the write-sequencing state type
// for the register file write arbiter.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches req starting one past ptr and
// returns the first hit as a one-hot grant plus its encoded index.
module rr_arbiter #(
   parameter int  NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port; each accepted request
// becomes an isolated one-cycle rf_reg_write pulse. ZERO_REG_PROTECT_EN suppresses writes to register 0.
//
// state  | meaning
// IDLE   | waiting for a request; winner's req_ready asserted, payload latched at the edge
// SETUP  | address/data presented to the file, strobe low
// STROBE | strobe high for one cycle, address/data unchanged
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int  NUM_REQ = 2,
   parameter int  DATA_W  = REG_DATA_W,
   parameter int  ADDR_W  = REG_ADDR_W,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [ADDR_W-1:0]         rf_write_reg,
   output logic [DATA_W-1:0]         rf_write_data,
   output logic                      rf_reg_write,
   output logic                      busy,
   output logic [IDX_W-1:0]          grant_id
);

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] win_onehot;
   logic [IDX_W-1:0]   win_idx;
   logic               any_req;
   logic               strobe_allow;

   logic [ADDR_W-1:0]  reg_arr  [NUM_REQ];
   logic [DATA_W-1:0]  data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign reg_arr[g]  = req_reg[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (win_onehot),
      .grant_idx (win_idx)
   );

   assign any_req = |req_valid;

   // Gated by rst_n so no requester sees an accept while reset is being applied.
   assign req_ready = (rst_n && state == IDLE) ? win_onehot : '0;
   assign busy      = (state != IDLE);

`ifdef ZERO_REG_PROTECT_EN
   assign strobe_allow = (rf_write_reg != ADDR_W'(REG_ZERO));
`else
   assign strobe_allow = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         grant_id      <= '0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
         rf_reg_write  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               rf_reg_write <= 1'b0;
               if (any_req) begin
                  rf_write_reg  <= reg_arr[win_idx];
                  rf_write_data <= data_arr[win_idx];
                  grant_id      <= win_idx;
                  rr_ptr        <= win_idx;
                  state         <= SETUP;
               end
            end
            SETUP: begin
               rf_reg_write <= strobe_allow;
               state        <= STROBE;
            end
            STROBE: begin
               rf_reg_write <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               rf_reg_write <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter (NUM_REQ=4): directed vector table, hand
// sequences for zero-register and mid-write reset, then randomized traffic.
module tb_regfile_write_arbiter;

   localparam int N = 4;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef ZERO_REG_PROTECT_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_reg;
   logic [N*DW-1:0] req_data;
   logic [AW-1:0]   rf_write_reg;
   logic [DW-1:0]   rf_write_data;
   logic            rf_reg_write;
   logic            busy;
   logic [1:0]      grant_id;

   regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_reg       (req_reg),
      .req_data      (req_data),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .rf_reg_write  (rf_reg_write),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // requester payloads
   logic [AW-1:0] a_reg  [N];
   logic [DW-1:0] a_data [N];

   // reference model: last accept, cycles since accept, final register file contents
   int            m_ptr, m_phase, m_gid, m_acc;
   logic [AW-1:0] m_reg;
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_rf [32];
   logic [DW-1:0] o_rf [32];
   bit            chk_en;

   // snapshot of DUT outputs for the current cycle
   logic [N-1:0]  o_ready;
   logic          o_busy, o_wr;
   logic [1:0]    o_gid;
   logic [AW-1:0] o_reg;
   logic [DW-1:0] o_data;

   // register file behaviour: writes on the rising edge of the strobe
   always @(posedge rf_reg_write) o_rf[rf_write_reg] = rf_write_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      logic [N-1:0] t;
      for (int k = 1; k <= N; k++) begin
         t = v >> ((p + k) % N);
         if (t[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic check_model();
      int w;
      logic [N-1:0] one;
      logic [N-1:0] exp_rdy;
      one = 1;
      w = rr_pick(req_valid, m_ptr);
      exp_rdy = (rst_n && m_phase == 0 && w >= 0) ? (one << w) : '0;
      chk("m_ready", o_ready, exp_rdy);
      chk("m_busy", o_busy, m_phase != 0);
      chk("m_strobe", o_wr, (m_phase == 2) && !(ZP && m_reg == 0));
      chk("m_grant_id", o_gid, m_gid);
      chk("m_wr_reg", o_reg, m_reg);
      chk("m_wr_data", o_data, m_data);
   endtask

   task automatic model_step();
      int w;
      m_acc = -1;
      if (!rst_n) begin
         m_ptr = 0; m_phase = 0; m_gid = 0; m_reg = '0; m_data = '0;
      end else if (m_phase == 0) begin
         w = rr_pick(req_valid, m_ptr);
         if (w >= 0) begin
            m_acc = w; m_ptr = w; m_gid = w;
            m_reg = a_reg[w]; m_data = a_data[w];
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
         if (!(ZP && m_reg == 0)) m_rf[m_reg] = m_data;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic cycle(input logic r, input logic [N-1:0] v);
      rst_n = r;
      req_valid = v;
      for (int i = 0; i < N; i++) begin
         req_reg[i*AW +: AW]  = a_reg[i];
         req_data[i*DW +: DW] = a_data[i];
      end
      #1;
      o_ready = req_ready; o_busy = busy; o_wr = rf_reg_write;
      o_gid = grant_id; o_reg = rf_write_reg; o_data = rf_write_data;
      if (chk_en) check_model();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          r;
      logic [N-1:0]  v;
      logic [N-1:0]  rdy;
      logic          bsy;
      logic          wr;
      logic [1:0]    gid;
      logic [AW-1:0] rg;
      logic [DW-1:0] dat;
   } vec_t;

   vec_t tbl [24];

   initial begin
      int nb, nw;
      logic [N-1:0] rv;
      logic r;

      tbl = '{
         '{1'b0, 4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0},
         '{1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0},
         '{1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b1001, 4'b1000, 1'b0, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0, 2'd3, 5'd3, 32'h33333333},
         '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 5'd3, 32'h33333333},
         '{1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 2'd3, 5'd3, 32'h33333333},
         '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF},
         '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 5'd7, 32'h11111111},
         '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 5'd7, 32'h11111111}
      };

      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; o_rf[i] = '0; end
      a_reg[0] = 5'd3; a_data[0] = 32'hDEADBEEF;
      a_reg[1] = 5'd7; a_data[1] = 32'h11111111;
      a_reg[2] = 5'd9; a_data[2] = 32'h22222222;
      a_reg[3] = 5'd3; a_data[3] = 32'h33333333;
      m_ptr = 0; m_phase = 0; m_gid = 0; m_reg = '0; m_data = '0; m_acc = -1;

      chk_en = 1'b0;
      cycle(1'b0, 4'b0011);
      cycle(1'b0, 4'b0011);
      chk_en = 1'b1;

      for (int k = 0; k < 24; k++) begin
         cycle(tbl[k].r, tbl[k].v);
         chk($sformatf("row%0d_ready", k), o_ready, tbl[k].rdy);
         chk($sformatf("row%0d_busy", k), o_busy, tbl[k].bsy);
         chk($sformatf("row%0d_strobe", k), o_wr, tbl[k].wr);
         chk($sformatf("row%0d_grant_id", k), o_gid, tbl[k].gid);
         chk($sformatf("row%0d_wr_reg", k), o_reg, tbl[k].rg);
         chk($sformatf("row%0d_wr_data", k), o_data, tbl[k].dat);
      end
      chk("same_index_last_wins", o_rf[3], 32'hDEADBEEF);

      // register 0 write: strobe only when protection is off
      a_reg[0] = 5'd0; a_data[0] = 32'h1;
      cycle(1'b1, 4'b0001);
      chk("zero_ready", o_ready, 4'b0001);
      nb = 0; nw = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 4'b0000);
         nb += int'(o_busy);
         nw += int'(o_wr);
      end
      chk("zero_busy_cycles", nb, 2);
      chk("zero_strobes", nw, ZP ? 0 : 1);
      chk("zero_rf0", o_rf[0], ZP ? 32'h0 : 32'h1);

      // reset during SETUP aborts the write; request is taken again afterwards
      a_reg[0] = 5'd5; a_data[0] = 32'hAA;
      cycle(1'b1, 4'b0001);
      chk("rst_accept_ready", o_ready, 4'b0001);
      cycle(1'b0, 4'b0001);
      chk("rst_in_setup_busy", o_busy, 1'b1);
      chk("rst_in_setup_strobe", o_wr, 1'b0);
      cycle(1'b1, 4'b0001);
      chk("rst_after_strobe", o_wr, 1'b0);
      chk("rst_after_busy", o_busy, 1'b0);
      chk("rst_reaccept_ready", o_ready, 4'b0001);
      cycle(1'b1, 4'b0000);
      chk("rst_retry_setup_strobe", o_wr, 1'b0);
      cycle(1'b1, 4'b0000);
      chk("rst_retry_strobe", o_wr, 1'b1);
      chk("rst_retry_reg", o_reg, 5'd5);
      cycle(1'b1, 4'b0000);

      // randomized traffic with drops and occasional resets
      rv = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rv[i]) begin
               if ($urandom_range(2) == 0) begin
                  rv[i] = 1'b1;
                  a_reg[i] = AW'($urandom_range(7));
                  a_data[i] = $urandom;
               end
            end else if ($urandom_range(15) == 0) begin
               rv[i] = 1'b0;
            end
         end
         r = ($urandom_range(199) != 0);
         cycle(r, rv);
         if (m_acc >= 0) rv[m_acc] = 1'b0;
      end
      for (int k = 0; k < 4; k++) cycle(1'b1, 4'b0000);

      for (int i = 0; i < 32; i++)
         chk($sformatf("rf_contents[%0d]", i), o_rf[i], m_rf[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
